// File: rtl/mio_bus_responder.sv
// mio_bus_responder: target side of the core's CPU_MIO / MemRW / MIO_ready handshake.
// Takes one word request at a time, holds it for a fixed wait, then returns a single-cycle
// MIO_ready pulse with registered read data.
//
// Address map (byte addresses, bits [1:0] ignored):
//   0x0000_0000 .. 4*2^RAM_AW-1 : external synchronous RAM (1-cycle read latency)
//   0xF000_0000                 : LED register, read/write
//   0xF000_0004                 : switch inputs, read-only (writes dropped, no error)
//   0xF000_0008                 : free-running 32-bit counter, read/write
//   anything else               : unmapped, reads return 0, writes dropped, bus_err=1
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   CPU_MIO, MemRW      request valid and direction (1=write)
//   Addr_in, Data_in    request byte address and write data
//   Data_out            registered read data, valid while MIO_ready=1, held otherwise
//   MIO_ready, bus_err  completion pulse and unmapped-address flag
//   ram_addr, ram_din   RAM word address and write data, driven from the request latches
//   ram_we, ram_dout    RAM write strobe and RAM read data
//   sw, led             switch inputs and LED register
//
// WAIT_CYCLES is the number of ACCESS cycles beyond the first; legal range 1..15.
module mio_bus_responder #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned RAM_AW      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CPU_MIO,
  input  logic              MemRW,
  input  logic [31:0]       Addr_in,
  input  logic [31:0]       Data_in,
  output logic [31:0]       Data_out,
  output logic              MIO_ready,
  output logic              bus_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw,
  output logic [15:0]       led
);

  localparam logic [31:0] LedAddr  = 32'hF000_0000;
  localparam logic [31:0] SwAddr   = 32'hF000_0004;
  localparam logic [31:0] CntAddr  = 32'hF000_0008;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  typedef enum logic [2:0] {
    RegRam,
    RegLed,
    RegSw,
    RegCnt,
    RegNone
  } region_e;

  function automatic region_e decode(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if ((wa >> (RAM_AW + 2)) == 32'd0) begin
      return RegRam;
    end else if (wa == LedAddr) begin
      return RegLed;
    end else if (wa == SwAddr) begin
      return RegSw;
    end else if (wa == CntAddr) begin
      return RegCnt;
    end else begin
      return RegNone;
    end
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] dout_q, dout_d;
  logic [15:0] led_q, led_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        ram_we_q, ram_we_d;
  region_e     region;

  assign region = decode(addr_q);

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    cnt_d    = cnt_q + 32'd1;
    dout_d   = dout_q;
    led_d    = led_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    ram_we_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (CPU_MIO) begin
          addr_d   = Addr_in;
          data_d   = Data_in;
          we_d     = MemRW;
          wait_d   = WaitInit;
          // Registered strobe: high exactly for the first ACCESS cycle.
          ram_we_d = MemRW && (decode(Addr_in) == RegRam);
          state_d  = StAccess;
        end
      end

      StAccess: begin
        if (wait_q == 4'd0) begin
          state_d = StResp;
          ready_d = 1'b1;
          err_d   = (region == RegNone);
          if (we_q) begin
            // Writes return zero data; only LED and CNT commit here (RAM wrote earlier).
            dout_d = 32'd0;
            if (region == RegLed) begin
              led_d = data_q[15:0];
            end
            if (region == RegCnt) begin
              cnt_d = data_q;
            end
          end else begin
            unique case (region)
              RegRam:  dout_d = ram_dout;
              RegLed:  dout_d = {16'b0, led_q};
              RegSw:   dout_d = {16'b0, sw};
              RegCnt:  dout_d = cnt_q;
              default: dout_d = 32'd0;
            endcase
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wait_q   <= 4'd0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      we_q     <= 1'b0;
      cnt_q    <= 32'd0;
      dout_q   <= 32'd0;
      led_q    <= 16'd0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      ram_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      led_q    <= led_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      ram_we_q <= ram_we_d;
    end
  end

  assign Data_out  = dout_q;
  assign MIO_ready = ready_q;
  assign bus_err   = err_q;
  assign led       = led_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = addr_q[RAM_AW+1:2];
  assign ram_din   = data_q;

endmodule

// File: doc/mio_bus_responder.md
Name: mio_bus_responder

Overview:
- Memory/IO bus responder for the single-cycle/multi-cycle RISC-V core; the target side of the core's CPU_MIO / MemRW / MIO_ready handshake.
- Accepts one word request at a time and decodes the address to data RAM, LED register, switch input or free-running counter.
- Completes each access after a fixed wait and returns MIO_ready plus read data.

Parameters:
- WAIT_CYCLES, 1, extra ACCESS cycles beyond the first; legal range 1..15.
- RAM_AW, 10, RAM word-address width; RAM window is 4*2^RAM_AW bytes starting at 0x0000_0000.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- CPU_MIO  in  1  request valid from core
- MemRW  in  1  1=write, 0=read
- Addr_in  in  32  byte address; bits [1:0] ignored
- Data_in  in  32  write data
- Data_out  out  32  registered read data, valid while MIO_ready=1
- MIO_ready  out  1  one-cycle completion pulse
- bus_err  out  1  high with MIO_ready when the address is unmapped
- ram_addr  out  RAM_AW  Addr_in[RAM_AW+1:2] of the latched request
- ram_din  out  32  latched write data
- ram_we  out  1  RAM write strobe
- ram_dout  in  32  synchronous RAM read data, 1-cycle latency
- sw  in  16  switch inputs
- led  out  16  LED register

Behaviour:
Reset (async, rst_n=0):
- Outputs: MIO_ready=0, bus_err=0, Data_out=0, led=0, ram_we=0.
- Internal: counter=0; state=IDLE; transaction latches cleared.
- Reset mid-transaction aborts it. No peripheral write is committed and no ready pulse is issued.

Address map:
- RAM: Addr_in below 4*2^RAM_AW.
- 0xF000_0000 LED: read/write; led=Data_in[15:0]; reads return {16'b0, led}.
- 0xF000_0004 SW: read-only; returns {16'b0, sw}; writes dropped without error.
- 0xF000_0008 CNT: read/write.
- Anything else is unmapped: reads return 0, writes are dropped, bus_err=1.

State machine: IDLE -> ACCESS -> RESP -> IDLE
- IDLE: on an edge with CPU_MIO=1, latch Addr_in, Data_in and MemRW, load wait counter = WAIT_CYCLES, go to ACCESS. Inputs are sampled only in IDLE.
- ACCESS:
  - Lasts exactly WAIT_CYCLES+1 cycles.
  - ram_addr and ram_din are driven from the latches throughout.
  - ram_we=1 only during the first ACCESS cycle, only for a RAM write.
  - CPU_MIO changes during ACCESS are ignored.
- ACCESS->RESP edge:
  - Data_out is loaded from the decoded source (ram_dout, led, sw, counter, or 0).
  - LED and CNT writes are committed.
  - MIO_ready and bus_err are registered.
- RESP: MIO_ready=1 for exactly one cycle, then IDLE. On the same edge MIO_ready falls and bus_err clears.

Latency and throughput:
- Request sampled at edge N gives MIO_ready high from edge N+WAIT_CYCLES+1 to edge N+WAIT_CYCLES+2.
- Minimum request-to-request spacing is WAIT_CYCLES+3 cycles, because one IDLE cycle is mandatory after RESP.

Counter:
- 32-bit; increments by 1 every clock and wraps from 0xFFFF_FFFF to 0.
- A CNT write loads Data_in on the commit edge; the write wins over the increment.
- A CNT read returns the value held just before the commit edge.

Other rules:
- Reads never modify state.
- Data_out holds its value outside RESP.
- ram_we is never asserted for a non-RAM address or for a read.

Test Plan:
- Reset, then RAM write: WAIT_CYCLES=1, write 0x0000_0010 <- 0xDEADBEEF. Expect ram_we high 1 cycle with ram_addr=4 and ram_din=0xDEADBEEF; MIO_ready high after edge N+2 for 1 cycle; bus_err=0.
- RAM read-back: read 0x0000_0010 with the RAM model returning the stored word. Expect Data_out=0xDEADBEEF with MIO_ready.
- LED/SW: write 0xF000_0000 <- 0x1234_A5A5 gives led=0xA5A5 after the commit edge. Read 0xF000_0004 with sw=0x00FF gives Data_out=0x0000_00FF.
- Counter wrap: write CNT <- 0xFFFF_FFFE; reads 5 and 6 cycles later return a consistent +1 delta with wrap through 0. Bench checks that the value equals commit-edge count mod 2^32.
- Unmapped access: read 0x8000_0000 gives Data_out=0 and bus_err=1 with MIO_ready. Write to the same address leaves led, counter and RAM unchanged.
- Abort and ignore: rst_n low during ACCESS of an LED write gives no MIO_ready and led=0. CPU_MIO dropped mid-ACCESS still completes with exactly one MIO_ready pulse.
